// File: rtl/alu_iterative.sv
// alu_iterative: multicycle ALU, single-cycle logic/arith ops, bit-serial shifts with start/done handshake.
// Optional signed overflow flag enabled by defining ALU_OVERFLOW_EN.
module alu_iterative #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [4:0]         ALUCtrl,
    input  logic               Sign,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               Zero,
    output logic               Overflow
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t               state_q;
    logic                 busy_q, done_q, zero_q, sll_q, sign_q;
    logic [SHAMT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]     sh_q, result_q;
    logic [WIDTH-1:0]     sum, diff, alu_d, sh_next, res_d;
    logic                 slt, shift_go, accept, res_we;

    always_comb begin
        sum      = in1 + in2;
        diff     = in1 - in2;
        slt      = Sign ? ($signed(in1) < $signed(in2)) : (in1 < in2);
        alu_d    = '0;
        case (ALUCtrl)
            5'd0:       alu_d = in1 & in2;
            5'd1:       alu_d = in1 | in2;
            5'd2:       alu_d = sum;
            5'd3:       alu_d = diff;
            5'd4:       alu_d = {{(WIDTH-1){1'b0}}, slt};
            5'd5:       alu_d = ~(in1 | in2);
            5'd6:       alu_d = in1 ^ in2;
            5'd7, 5'd8: alu_d = in2;
            5'd9:       alu_d = in2 << 16;
            default:    alu_d = '0;
        endcase
        accept   = (state_q == IDLE) && start;
        shift_go = (ALUCtrl == 5'd7 || ALUCtrl == 5'd8) && (in1[SHAMT_W-1:0] != '0);
        sh_next  = sll_q ? {sh_q[WIDTH-2:0], 1'b0} : {sign_q & sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
        res_we   = (accept && !shift_go) || (state_q == SHIFT && cnt_q == SHAMT_W'(1));
        res_d    = (state_q == SHIFT) ? sh_next : alu_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sll_q   <= 1'b0;
            sign_q  <= 1'b0;
            cnt_q   <= '0;
            sh_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sll_q  <= (ALUCtrl == 5'd7);
                        sign_q <= Sign;
                        sh_q   <= in2;
                        cnt_q  <= in1[SHAMT_W-1:0];
                        state_q <= shift_go ? SHIFT : DONE;
                        busy_q  <= shift_go;
                        done_q  <= !shift_go;
                    end
                end
                SHIFT: begin
                    sh_q  <= sh_next;
                    cnt_q <= cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b1;
        end else if (res_we) begin
            result_q <= res_d;
            zero_q   <= (res_d == '0);
        end
    end

`ifdef ALU_OVERFLOW_EN
    logic ovf_q, ovf_d;
    always_comb begin
        ovf_d = Sign && (((ALUCtrl == 5'd2) && (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1])) ||
                         ((ALUCtrl == 5'd3) && (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1])));
    end
    always_ff @(posedge clk) begin
        if (reset)
            ovf_q <= 1'b0;
        else if (res_we)
            ovf_q <= (state_q == IDLE) && ovf_d;
    end
    assign Overflow = ovf_q;
`else
    assign Overflow = 1'b0;
`endif

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign Zero   = zero_q;
endmodule

// File: tb/tb_alu_iterative.sv
// tb_alu_iterative: table-driven vectors with a scoreboard queue, plus hand-written
// sequences for start-during-DONE and reset mid-shift.
module tb_alu_iterative;
    typedef struct {
        logic [4:0]  op;
        logic        sign;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
        int          lat;
        bit          mid;
    } vec_t;
    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, Sign = 1'b0;
    logic [4:0]  ALUCtrl = '0;
    logic [31:0] in1 = '0, in2 = '0;
    logic        busy, done, Zero, Overflow;
    logic [31:0] result;
    int          n_cmp = 0, n_err = 0;
    exp_t        sb[$];
`ifdef ALU_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    alu_iterative #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .ALUCtrl(ALUCtrl), .Sign(Sign),
        .in1(in1), .in2(in2), .busy(busy), .done(done), .result(result),
        .Zero(Zero), .Overflow(Overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic issue(input vec_t v);
        int cyc, bsy, g;
        exp_t e;
        @(negedge clk);
        g = 0;
        while ((busy || done) && g < 100) begin
            @(negedge clk);
            g++;
        end
        ALUCtrl = v.op; Sign = v.sign; in1 = v.a; in2 = v.b; start = 1'b1;
        e.res = v.res; e.z = (v.res == 32'd0); e.ovf = v.ovf & OVF_EN;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0; in1 = $urandom; in2 = $urandom;
        ALUCtrl = 5'($urandom_range(0, 15)); Sign = 1'($urandom_range(0, 1));
        cyc = 1; bsy = 0;
        while (!done && cyc < 100) begin
            if (busy) bsy++;
            start = v.mid && (cyc == 10);
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        check($sformatf("latency op%0d", v.op), cyc, v.lat);
        check($sformatf("busy_cycles op%0d", v.op), bsy, v.lat - 1);
        if (done && sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("result op%0d", v.op), result, e.res);
            check($sformatf("zero op%0d", v.op), {31'd0, Zero}, {31'd0, e.z});
            check($sformatf("ovf op%0d", v.op), {31'd0, Overflow}, {31'd0, e.ovf});
            @(posedge clk); #1;
            check($sformatf("done_pulse op%0d", v.op), {31'd0, done}, 32'd0);
            check($sformatf("hold op%0d", v.op), result, e.res);
        end else begin
            n_cmp++; n_err++;
            $display("FAIL timeout op%0d: no done within %0d cycles", v.op, cyc);
        end
    endtask

    initial begin
        vec_t vecs[$];
        vecs = '{
            '{5'd2,  1'b1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1,  1'b0},
            '{5'd4,  1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1,  1'b0},
            '{5'd4,  1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1,  1'b0},
            '{5'd8,  1'b1, 32'h00000004, 32'h80000000, 32'hF8000000, 1'b0, 5,  1'b0},
            '{5'd8,  1'b0, 32'h00000004, 32'h80000000, 32'h08000000, 1'b0, 5,  1'b0},
            '{5'd7,  1'b0, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1,  1'b0},
            '{5'd7,  1'b0, 32'h0000001F, 32'h00000001, 32'h80000000, 1'b0, 32, 1'b1},
            '{5'd3,  1'b1, 32'h00001234, 32'h00001234, 32'h00000000, 1'b0, 1,  1'b0},
            '{5'd9,  1'b0, 32'h00000000, 32'h0000ABCD, 32'hABCD0000, 1'b0, 1,  1'b0},
            '{5'd15, 1'b0, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1,  1'b0},
            '{5'd0,  1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1,  1'b0},
            '{5'd1,  1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1,  1'b0},
            '{5'd5,  1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1,  1'b0},
            '{5'd6,  1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1,  1'b0},
            '{5'd3,  1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1,  1'b0},
            '{5'd2,  1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1,  1'b0},
            '{5'd7,  1'b0, 32'h00000024, 32'h00000003, 32'h00000030, 1'b0, 5,  1'b0},
            '{5'd8,  1'b1, 32'h00000001, 32'h7FFFFFFE, 32'h3FFFFFFF, 1'b0, 2,  1'b0}
        };
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset zero", {31'd0, Zero}, 32'd1);
        check("reset ovf", {31'd0, Overflow}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) issue(vecs[i]);

        // start held during the DONE cycle must not launch a second op
        @(negedge clk);
        ALUCtrl = 5'd0; Sign = 1'b0; in1 = 32'h000000FF; in2 = 32'h0000000F; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("dc done", {31'd0, done}, 32'd1);
        check("dc result", result, 32'h0000000F);
        @(negedge clk);
        ALUCtrl = 5'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("dc ignored done", {31'd0, done}, 32'd0);
        check("dc ignored busy", {31'd0, busy}, 32'd0);
        check("dc ignored result", result, 32'h0000000F);

        // reset during the third shift cycle of a 20-bit shift
        @(negedge clk);
        ALUCtrl = 5'd8; Sign = 1'b0; in1 = 32'd20; in2 = 32'hFFFF0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("rs busy", {31'd0, busy}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rs busy after", {31'd0, busy}, 32'd0);
        check("rs done after", {31'd0, done}, 32'd0);
        check("rs result", result, 32'd0);
        check("rs zero", {31'd0, Zero}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        ALUCtrl = 5'd2; Sign = 1'b0; in1 = 32'd100; in2 = 32'd23; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("rs add done", {31'd0, done}, 32'd1);
        check("rs add result", result, 32'd123);
        check("rs add zero", {31'd0, Zero}, 32'd0);
        begin
            int extra = 0;
            repeat (25) begin
                @(posedge clk); #1;
                if (done) extra++;
            end
            check("rs no stale done", extra, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_iterative.md
Name: alu_iterative

Overview:
- Multicycle-datapath ALU that consumes the 5-bit ALU operation code and Sign bit produced by the ALU control decoder.
- Executes the decoded operation on two operands with a start/done handshake.
- Logic/arithmetic ops complete in one cycle. Shifts run bit-serially, one bit position per cycle, so the controller FSM waits on done.
- Result and Zero are registered and held for the controller's writeback and branch states.

Parameters:
- WIDTH, 32, operand/result width
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- ALUCtrl  input  5  op code: 0 And, 1 Or, 2 Add, 3 Sub, 4 Slt, 5 Nor, 6 Xor, 7 Sll, 8 Srx, 9 Lui
- Sign  input  1  1 = signed Slt / arithmetic Srx; 0 = unsigned Slt / logical Srx
- in1  input  WIDTH  operand A; shift amount = in1[SHAMT_W-1:0]
- in2  input  WIDTH  operand B; value shifted for Sll/Srx/Lui
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: result valid
- result  output  WIDTH  registered result, held until next completion
- Zero  output  1  registered (result == 0)
- Overflow  output  1  signed overflow flag (see Optional Feature)

Behaviour:
- Reset: busy=0, done=0, result=0, Zero=1, Overflow=0, FSM to IDLE. Applies on any cycle, including mid-shift; an in-flight operation is discarded with no done pulse.
- FSM states:
  - IDLE: busy=0.
  - SHIFT: busy=1.
  - DONE: busy=0, done=1 for exactly one cycle, then return to IDLE.
- start=1 in IDLE, sampled at edge of cycle N: latch ALUCtrl, Sign, in1, in2.
  - Single-cycle ops (0-6, 9, and any undefined code): compute and register result at that edge. DONE during cycle N+1.
  - Sll/Srx with amount k=0: result=in2, DONE during cycle N+1.
  - Sll/Srx with k>0: SHIFT for cycles N+1..N+k, one bit position per edge, down-counter of SHAMT_W bits. DONE during cycle N+k+1.
  - Latency = 1 + k cycles; max 1+(WIDTH-1).
- start while busy=1, or during the DONE cycle: ignored. No queuing. Latched operands are unaffected by input changes after acceptance.
- The done cycle may be followed immediately by a new start (back-to-back issue accepted in IDLE on the next cycle).
- Arithmetic:
  - Add/Sub: modulo 2^WIDTH, carry discarded.
  - Slt: 1 if in1<in2 (signed if Sign=1, else unsigned), else 0, zero-extended.
  - Nor: ~(in1|in2).
  - Lui: {in2[15:0], 16'b0} for WIDTH=32, i.e. in2<<16.
  - Srx with Sign=1: fill with in2 MSB each step (sra). Sign=0: fill with 0 (srl).
  - Undefined codes (10-31): result=0.
- Zero and Overflow update only at the same edge as result; held otherwise.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- Defined: Overflow registered with result, 1 when ALUCtrl is Add or Sub with Sign=1 and signed overflow occurs:
  - Add: operands same sign, result sign differs.
  - Sub: operands differ in sign, result sign differs from in1.
  - 0 for all other ops.
- Not defined: Overflow is constant 0 and no overflow logic is synthesized. Port remains present.

Test Plan:
- Add, Sign=1, in1=0x7FFFFFFF, in2=1, start at cycle N -> done at N+1, result=0x80000000, Zero=0, Overflow=1 (macro on) / 0 (macro off).
- Slt, in1=0xFFFFFFFF, in2=1: Sign=1 -> result=1; Sign=0 -> result=0; each done exactly 1 cycle after start.
- Srx, Sign=1, in2=0x80000000, in1=4 -> busy for 4 cycles, done at N+5, result=0xF8000000. Repeat with Sign=0 -> 0x08000000.
- Sll, in1=0 -> done at N+1, result=in2. Sll, in1=31, in2=1 -> done at N+32, result=0x80000000. A start pulsed mid-shift is ignored, result unchanged.
- Sub, in1=in2=0x1234 -> result=0, Zero=1. Then Lui, in2=0x0000ABCD -> result=0xABCD0000, Zero=0. Then ALUCtrl=15 -> result=0.
- Reset asserted at cycle 3 of a 20-bit shift -> next cycle busy=0, result=0, Zero=1, no done pulse. New Add start accepted on the following cycle.
